// File: rtl/core_shift_iter.sv
// core_shift_iter: multi-cycle shift sequencer.
//
// Purpose: accepts one shift request at a time over a valid/ready handshake.
// The shift is performed as a series of partial shifts of at most STEP bits
// per cycle, and the result is returned over a second valid/ready handshake.
// This is the area-saving alternative to the single-cycle barrel shifter and
// uses the same operation codes and result semantics. The shift amount is
// masked to SHAMT_W bits, which gives RISC-V 5-bit masking for 32-bit data.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_valid    request present
//   req_ready    block can accept a request (IDLE only)
//   req_control  operation code (sll/srl/sra; anything else is a null op)
//   req_a        value to shift
//   req_b        shift amount; only the low SHAMT_W bits are used
//   rsp_valid    result available (DONE)
//   rsp_ready    consumer takes the result
//   rsp_data     registered shift result
//   busy         high whenever the sequencer is not IDLE

package core_pkg;
  localparam int DATA_WIDTH = 32;
endpackage

package shift_control_pkg;
  localparam int SHIFT_WIDTH_CODE = 2;
  localparam logic [SHIFT_WIDTH_CODE-1:0] shift_none = 2'd0;
  localparam logic [SHIFT_WIDTH_CODE-1:0] shift_sll  = 2'd1;
  localparam logic [SHIFT_WIDTH_CODE-1:0] shift_srl  = 2'd2;
  localparam logic [SHIFT_WIDTH_CODE-1:0] shift_sra  = 2'd3;
endpackage

module core_shift_iter #(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
  parameter int STEP       = 4,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [shift_control_pkg::SHIFT_WIDTH_CODE-1:0] req_control,
  input  logic [DATA_WIDTH-1:0]                       req_a,
  input  logic [DATA_WIDTH-1:0]                       req_b,
  output logic                                        rsp_valid,
  input  logic                                        rsp_ready,
  output logic [DATA_WIDTH-1:0]                       rsp_data,
  output logic                                        busy
);
  import shift_control_pkg::*;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // The step limit is held at the width of the remaining-count so the
  // min() comparison needs no width juggling.
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(STEP);

  state_t                      state_q, state_d;
  logic [DATA_WIDTH-1:0]       acc_q, acc_d;
  logic [DATA_WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic [SHAMT_W:0]            rem_q, rem_d;
  logic [SHIFT_WIDTH_CODE-1:0] op_q, op_d;
  logic                        req_ready_q, req_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        busy_q, busy_d;
  logic [SHAMT_W:0]            step;
  logic [DATA_WIDTH-1:0]       shifted;
  logic                        req_is_shift;
  logic [SHAMT_W-1:0]          req_shamt;

  // Upper shift-amount bits are deliberately ignored.
  logic unused_req_b_hi;
  assign unused_req_b_hi = ^req_b[DATA_WIDTH-1:SHAMT_W];

  assign req_shamt    = req_b[SHAMT_W-1:0];
  assign req_is_shift = (req_control == shift_sll) ||
                        (req_control == shift_srl) ||
                        (req_control == shift_sra);

  // Next-state logic. The handshake flags are registered from the next
  // state so no output has a combinational path from the inputs.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;

    step = (rem_q < STEP_W) ? rem_q : STEP_W;

    // The arithmetic shift fills from acc's MSB, which still holds the
    // original sign because only right shifts are ever applied for sra.
    case (op_q)
      shift_sll: shifted = acc_q << step;
      shift_srl: shifted = acc_q >> step;
      shift_sra: shifted = DATA_WIDTH'($signed(acc_q) >>> step);
      default:   shifted = acc_q;
    endcase

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          acc_d = req_a;
          op_d  = req_control;
          rem_d = {1'b0, req_shamt};
          if (!req_is_shift) begin
            acc_d      = '0;
            rsp_data_d = '0;
            state_d    = DONE;
          end else if (req_shamt == '0) begin
            rsp_data_d = req_a;
            state_d    = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = shifted;
        rem_d = rem_q - step;
        if (rem_d == '0) begin
          rsp_data_d = shifted;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs. Reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      op_q        <= shift_none;
      rsp_data_q  <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      rsp_data_q  <= rsp_data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_core_shift_iter.sv
// Testbench for core_shift_iter: directed requests with literal expected
// results and latencies, plus a cycle-level reference model compared
// against the DUT outputs on every falling edge.
module tb_core_shift_iter;
  import shift_control_pkg::*;

  localparam int DW   = 32;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_control;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_shift_iter #(.DATA_WIDTH(DW), .STEP(STEP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_control(req_control), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  // Single comparison point: every check counts and reports here.
  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Result of a request straight from the operation definitions.
  function automatic logic [DW-1:0] modelResult(input logic [1:0] c,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
    int n;
    n = int'(b[4:0]);
    case (c)
      shift_sll: return a << n;
      shift_srl: return a >> n;
      shift_sra: return DW'($signed(a) >>> n);
      default:   return '0;
    endcase
  endfunction

  // Cycles from the accept edge until the response is visible.
  function automatic int modelLatency(input logic [1:0] c, input logic [DW-1:0] b);
    int n;
    n = int'(b[4:0]);
    if (c == shift_none || n == 0) return 1;
    return 1 + (n + STEP - 1) / STEP;
  endfunction

  // Reference model: a countdown to the response rather than a state machine.
  bit            m_valid = 0;
  bit            m_rst_last = 1;
  bit            m_done = 0;
  bit            m_was_ready;
  int            m_wait = 0;
  int            m_lat;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_result = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid    = 1;
      m_rst_last = 1;
      m_done     = 0;
      m_wait     = 0;
      m_data     = '0;
    end else begin
      m_was_ready = !m_rst_last && !m_done && (m_wait == 0);
      m_rst_last  = 0;
      if (m_done) begin
        if (rsp_ready) m_done = 0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_done = 1;
          m_data = m_result;
        end
      end else if (req_valid && m_was_ready) begin
        m_result = modelResult(req_control, req_a, req_b);
        m_lat    = modelLatency(req_control, req_b);
        if (m_lat == 1) begin
          m_done = 1;
          m_data = m_result;
        end else begin
          m_wait = m_lat - 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("cmp_busy", busy, m_done || (m_wait > 0));
      checkOutput("cmp_rsp_valid", rsp_valid, m_done);
      checkOutput("cmp_req_ready", req_ready, !m_rst_last && !m_done && (m_wait == 0));
      checkOutput("cmp_rsp_data", rsp_data, m_data);
    end
  end

  // Issue one request, measure latency, optionally stall the response.
  task automatic applyStimulus(input logic [1:0] c, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [DW-1:0] exp_data,
                               input int exp_lat, input int stall);
    int cyc;
    @(negedge clk);
    checkOutput("pre_accept_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_control = c; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency", cyc, exp_lat);
    checkOutput("rsp_data", rsp_data, exp_data);
    if (stall > 0) begin
      req_valid = 1'b1; req_control = shift_sll; req_a = 32'h0000_00FF; req_b = 32'd1;
      repeat (stall) begin
        @(negedge clk);
        checkOutput("stall_rsp_valid", rsp_valid, 1'b1);
        checkOutput("stall_rsp_data", rsp_data, exp_data);
        checkOutput("stall_req_ready", req_ready, 1'b0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("post_busy", busy, 1'b0);
    checkOutput("post_req_ready", req_ready, 1'b1);
    checkOutput("post_rsp_valid", rsp_valid, 1'b0);
  endtask

  // Directed sequence with hand-computed results and latencies.
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_control = shift_none;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 1'b0);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_data", rsp_data, 32'h0);
    checkOutput("reset_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_after_reset", req_ready, 1'b1);

    applyStimulus(shift_sll, 32'h0000_0001, 32'd5,       32'h0000_0020, 3, 0);
    applyStimulus(shift_sra, 32'h8000_0000, 32'd31,      32'hFFFF_FFFF, 9, 0);
    applyStimulus(shift_srl, 32'h8000_0000, 32'd31,      32'h0000_0001, 9, 0);
    applyStimulus(shift_srl, 32'hF000_0000, 32'h25,      32'h0780_0000, 3, 0);
    applyStimulus(shift_sll, 32'hDEAD_BEEF, 32'd0,       32'hDEAD_BEEF, 1, 0);
    applyStimulus(shift_none, 32'h1234_5678, 32'd3,      32'h0000_0000, 1, 0);
    applyStimulus(shift_sra, 32'h7000_0000, 32'd6,       32'h01C0_0000, 3, 0);
    applyStimulus(shift_sra, 32'hF000_0010, 32'd4,       32'hFF00_0001, 2, 0);
    applyStimulus(shift_sll, 32'h0000_0003, 32'd4,       32'h0000_0030, 2, 3);

    // Reset in the middle of a long shift discards the result.
    @(negedge clk);
    req_valid = 1'b1; req_control = shift_sra; req_a = 32'h8000_0000; req_b = 32'd31;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midshift_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_rsp_valid", rsp_valid, 1'b0);
    checkOutput("abort_rsp_data", rsp_data, 32'h0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ready_after", req_ready, 1'b1);
    applyStimulus(shift_sll, 32'h0000_0001, 32'd1, 32'h0000_0002, 2, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global safety net against a stuck sequence.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/core_shift_iter.md
# core_shift_iter

Multi-cycle shift sequencer for the execution stage. It accepts one shift request at a time over a valid/ready handshake and performs the shift as a series of partial shifts of at most STEP bits per cycle. It returns the result over a second valid/ready handshake. It replaces the single-cycle barrel shifter where area matters, keeping the same shift_control_pkg operation codes and result semantics, with RISC-V 5-bit shift-amount masking for DATA_WIDTH=32.

## Interface
- DATA_WIDTH, 32 (from core_pkg): operand/result width.
- STEP, 4: maximum bits shifted per cycle. Power of two, 1..DATA_WIDTH.
- SHAMT_W, $clog2(DATA_WIDTH): width of the used shift amount.
- clk  in  1  clock. One clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_control  in  SHIFT_WIDTH_CODE  operation: shift_sll / shift_srl / shift_sra; any other code, including shift_none, is a null op.
- req_a  in  DATA_WIDTH  value to shift (signed for sra).
- req_b  in  DATA_WIDTH  shift amount; only bits [SHAMT_W-1:0] are used.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  DATA_WIDTH  shift result.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - req_ready = 1 (0 while rst is high).
  - On req_valid && req_ready, capture:
    - acc ← req_a
    - op ← req_control
    - remaining ← req_b[SHAMT_W-1:0]
  - Then choose the next state:
    - null op: acc ← 0, go to DONE.
    - remaining == 0: go to DONE; result = req_a.
    - otherwise: go to SHIFT.
- **SHIFT**
  - Each cycle: step = min(remaining, STEP); remaining ← remaining − step.
  - acc update by op:
    - sll: acc ← acc << step
    - srl: acc ← acc >> step (zero fill)
    - sra: acc ← acc >>> step (fill with acc MSB, which preserves the original sign)
  - Go to DONE when the updated remaining == 0.
  - New requests are not accepted.
- **DONE**
  - rsp_valid = 1; rsp_data = acc, held stable until handshake.
  - On rsp_ready: go to IDLE.
  - req_ready = 0 throughout DONE. There is no accept-and-respond in the same cycle.
- Width rules:
  - remaining is SHAMT_W+1 bits, so no underflow.
  - Bits of req_b above SHAMT_W-1 are ignored.
  - All shifts are truncated to DATA_WIDTH.
- Reset (any state, including mid-SHIFT or DONE):
  - Next state IDLE; acc, remaining and op cleared.
  - The in-flight result is discarded and never presented.
- The block is not pipelined: at most one request is in flight.

## Timing
- Reset values: req_ready=0 during rst, 1 the cycle after rst deasserts; rsp_valid=0; rsp_data=0; busy=0.
- Accept edge E0 (req_valid && req_ready).
  - rsp_valid rises in cycle 1 + ceil(n/STEP) after E0, where n = masked shift amount.
  - n=0 or null op: 1 cycle.
  - STEP=4, DATA_WIDTH=32: worst case n=31 gives 9 cycles.
- rsp_data is registered; it changes only on the edge entering DONE.
- req_ready, rsp_valid and busy are decoded from the registered state only. There are no combinational paths from req_* or rsp_ready to any output.
- Minimum request spacing: latency + 1 cycle, because IDLE must be re-entered after the response handshake.
- rsp_ready held low: the block stays in DONE indefinitely with rsp_data and rsp_valid stable.

## Test plan
- Defaults assumed: DATA_WIDTH=32, STEP=4.
- sll, a=0x00000001, b=5, rsp_ready=1 -> rsp_data=0x00000020, rsp_valid 3 cycles after accept; busy high for 3 cycles.
- sra, a=0x80000000, b=31 -> rsp_data=0xFFFFFFFF after 9 cycles. srl with the same operands -> 0x00000001.
- srl, a=0xF0000000, b=0x25 (masked to 5) -> 0x07800000. sll, a=0xDEADBEEF, b=0 -> 0xDEADBEEF after 1 cycle.
- shift_none, a=0x12345678, b=3 -> rsp_data=0 after 1 cycle; req_ready low until the response handshake.
- sll result with rsp_ready low for 3 cycles:
  - rsp_data and rsp_valid stay stable and req_ready stays 0.
  - A req_valid offered during that time is not accepted.
  - The block returns to IDLE the cycle after rsp_ready rises.
- Assert rst during SHIFT for a b=31 request:
  - Next cycle: state IDLE, rsp_valid=0, rsp_data=0, busy=0.
  - After rst deasserts, a new request (sll, a=1, b=1) returns 0x00000002 after 2 cycles.
